// File: rtl/quan_psum_accumulator_if.sv
// Stream bundle between a quantised PE output bus and the partial-sum accumulator,
// carrying both the tile-beat input channel and the group-result output channel.
interface quan_psum_accumulator_if #(
  parameter int PE_OUT_W = 64,
  parameter int ACC_W    = 32,
  parameter int CNT_W    = 9
);
  logic [3:0]          mode;
  logic                in_valid;
  logic                in_ready;
  logic [PE_OUT_W-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [4*ACC_W-1:0]  out_data;
  logic                out_mode;
  logic                out_sat;
  logic [CNT_W-1:0]    out_tiles;

  // Producer of beats and consumer of results.
  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_sat, out_tiles
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_sat, out_tiles
  );
endinterface

// File: rtl/quan_psum_accumulator.sv
// Accumulates PE partial sums over input-channel tiles per output group and emits one
// saturated, lane-packed result per group over a valid/ready channel.
module quan_psum_accumulator #(
  parameter int PE_OUT_W  = 64,
  parameter int ACC_W     = 32,
  parameter int MAX_TILES = 256,
  parameter int CNT_W     = 9
) (
  input logic clk,
  input logic reset,
  quan_psum_accumulator_if.slave bus
);

  // One guard bit above the wider of accumulator and 24b lane keeps the sum exact.
  localparam int SUM_W = ((ACC_W > 24) ? ACC_W : 24) + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [SUM_W-1:0] ZERO    = '0;

  logic                    first;
  logic                    mode_q;
  logic                    sat_q;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc [4];

  logic                    out_valid_q;
  logic [4*ACC_W-1:0]      out_data_q;
  logic                    out_mode_q;
  logic                    out_sat_q;
  logic [CNT_W-1:0]        out_tiles_q;

  logic                    eff_mode;
  logic                    fire;
  logic                    close;
  logic [CNT_W-1:0]        cnt_next;
  logic signed [SUM_W-1:0] lane [4];
  logic signed [SUM_W-1:0] sum [4];
  logic signed [ACC_W-1:0] acc_next [4];
  logic                    any_clamp;
  logic                    sat_next;
  logic [4*ACC_W-1:0]      acc_flat;
  logic                    unused_ok;

  assign unused_ok = &{1'b0, bus.mode[3:1], bus.in_data[PE_OUT_W-1:48]};

  assign bus.in_ready  = ~reset & (~out_valid_q | bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_tiles = out_tiles_q;

  // The first beat of a group picks the lane layout; later beats reuse the latched one.
  assign eff_mode = first ? bus.mode[0] : mode_q;
  assign fire     = bus.in_valid & bus.in_ready;
  assign cnt_next = first ? CNT_W'(1) : cnt + CNT_W'(1);
  assign close    = fire & (bus.in_last | (cnt_next == CNT_W'(MAX_TILES)));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane[k] = ZERO;
    end
    if (eff_mode) begin
      for (int k = 0; k < 4; k++) begin
        lane[k] = SUM_W'($signed(bus.in_data[16*k +: 16]));
      end
    end else begin
      lane[0] = SUM_W'($signed(bus.in_data[23:0]));
      lane[1] = SUM_W'($signed(bus.in_data[47:24]));
    end
  end

  // Saturating add per lane; the first beat of a group starts from zero.
  always_comb begin
    any_clamp = 1'b0;
    acc_flat  = '0;
    for (int k = 0; k < 4; k++) begin
      sum[k] = (first ? ZERO : SUM_W'(acc[k])) + lane[k];
      if (sum[k] > ACC_MAX) begin
        acc_next[k] = ACC_MAX[ACC_W-1:0];
        any_clamp   = 1'b1;
      end else if (sum[k] < ACC_MIN) begin
        acc_next[k] = ACC_MIN[ACC_W-1:0];
        any_clamp   = 1'b1;
      end else begin
        acc_next[k] = sum[k][ACC_W-1:0];
      end
      acc_flat[k*ACC_W +: ACC_W] = acc_next[k];
    end
    sat_next = (first ? 1'b0 : sat_q) | any_clamp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first  <= 1'b1;
      mode_q <= 1'b0;
      sat_q  <= 1'b0;
      cnt    <= '0;
      for (int k = 0; k < 4; k++) begin
        acc[k] <= '0;
      end
    end else if (fire) begin
      for (int k = 0; k < 4; k++) begin
        acc[k] <= acc_next[k];
      end
      mode_q <= eff_mode;
      sat_q  <= sat_next;
      if (close) begin
        first <= 1'b1;
        cnt   <= '0;
      end else begin
        first <= 1'b0;
        cnt   <= cnt_next;
      end
    end
  end

  // A closing beat can only be accepted when the result slot is free or being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_tiles_q <= '0;
    end else if (close) begin
      out_valid_q <= 1'b1;
      out_data_q  <= acc_flat;
      out_mode_q  <= eff_mode;
      out_sat_q   <= sat_next;
      out_tiles_q <= cnt_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
